// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-handling path.
package cache_pkg;

  localparam int LINE_WORDS  = 2;
  localparam int WORD_BYTES  = 4;
  localparam int WORD_W      = WORD_BYTES * 8;
  localparam int OFFSET_BITS = $clog2(LINE_WORDS * WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: writes back a dirty victim line word by word,
// then fetches the missing line from memory and hands it to the cache with
// a one-cycle refill_valid pulse. Every output is a register.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_req,
  input  logic                             wb_req,
  input  logic [ADDR_WIDTH-1:0]            miss_addr,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] wb_line,
  output logic                             busy,
  output logic                             refill_valid,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] refill_line,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  input  logic                             mem_ack
);
  import cache_pkg::*;

  localparam int OFF_BITS = $clog2(LINE_WORDS * WORD_BYTES);
  localparam int CNT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

  typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] buf_t;

  state_e                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  ack_ok;
  logic                  last_word;

  logic [ADDR_WIDTH-1:0] miss_base, wb_base;
  buf_t                  wb_buf;
  buf_t                  line_buf;
  buf_t                  wb_line_v;

  logic [ADDR_WIDTH-1:0] miss_sel, wb_sel, word_off;
  buf_t                  wbuf_sel;
  logic                  busy_n, refill_valid_n, mem_req_n, mem_we_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic [DATA_WIDTH-1:0] mem_wdata_n;

  assign wb_line_v   = wb_line;
  assign refill_line = line_buf;

  // Clear the in-line offset so every burst starts at the line base.
  function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};
  endfunction

  // State and word counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: an ack only counts while a request is actually on the bus.
  always_comb begin
    ack_ok    = mem_req && mem_ack && ((state == WB) || (state == FILL));
    last_word = (cnt == LAST);
    state_n   = state;
    cnt_n     = cnt;
    case (state)
      IDLE: begin
        if (fetch_req) begin
          state_n = wb_req ? WB : FILL;
          cnt_n   = '0;
        end
      end
      WB: begin
        if (ack_ok) begin
          if (last_word) begin
            state_n = FILL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      FILL: begin
        if (ack_ok) begin
          if (last_word) begin
            state_n = DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Next output values. In IDLE the latched copies are not loaded yet, so the
  // first word of a burst is addressed from the live inputs. The final ack of
  // a state always drops mem_req for one cycle, including WB -> FILL.
  always_comb begin
    miss_sel       = (state == IDLE) ? line_base(miss_addr) : miss_base;
    wb_sel         = (state == IDLE) ? line_base(wb_addr)   : wb_base;
    wbuf_sel       = (state == IDLE) ? wb_line_v            : wb_buf;
    word_off       = ADDR_WIDTH'(cnt_n) << 2;
    mem_req_n      = ((state_n == WB) || (state_n == FILL)) && !(ack_ok && last_word);
    mem_we_n       = (state_n == WB);
    mem_addr_n     = mem_addr;
    mem_wdata_n    = '0;
    busy_n         = (state_n != IDLE);
    refill_valid_n = (state_n == DONE);
    if (state_n == WB) begin
      mem_addr_n  = wb_sel + word_off;
      mem_wdata_n = wbuf_sel[cnt_n];
    end else if (state_n == FILL) begin
      mem_addr_n  = miss_sel + word_off;
    end
  end

  // Registered outputs and the refill line buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      refill_valid <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      line_buf     <= '0;
    end else begin
      busy         <= busy_n;
      refill_valid <= refill_valid_n;
      mem_req      <= mem_req_n;
      mem_we       <= mem_we_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
      if (ack_ok && (state == FILL)) begin
        line_buf[cnt] <= mem_rdata;
      end
    end
  end

  // Request snapshot: addresses and victim data are frozen at acceptance.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && fetch_req) begin
      miss_base <= line_base(miss_addr);
      wb_base   <= line_base(wb_addr);
      wb_buf    <= wb_line_v;
    end
  end

endmodule
